// File: rtl/addr_seq9_pkg.sv
// Shared types and constants for the addr_seq9 burst address generator.
// Optional build macro: ADDR_SEQ_PAUSE_EN adds a pause input to the top level.
package addr_seq_pkg;

    localparam int AW = 9;
    localparam int SW = 4;
    localparam int LW = AW + 1;

    // Largest burst: every line of the decoded space exactly once.
    localparam logic [LW-1:0] LEN_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp a requested burst length to the size of the decoded space.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] v);
        logic [LW-1:0] res;
        if (v > LEN_MAX) begin
            res = LEN_MAX;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/addr_seq9_len_counter.sv
// Loadable down-counter tracking how many addresses of a burst remain.
// o_last flags the final address (count == 1).
module len_counter
    import addr_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_dec,
    input  logic [LW-1:0] i_load_val,
    output logic          o_last
);

    logic [LW-1:0] r_count;

    // Remaining-address counter: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {LW{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {LW{1'b0}})) begin
            r_count <= r_count - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_last = (r_count == {{(LW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/addr_seq9.sv
// Burst address generator feeding the 9-to-512 one-hot row decoder.
// A start pulse in IDLE launches a burst of base, base+stride, ... (mod 512).
// Optional build macro: ADDR_SEQ_PAUSE_EN adds a `pause` input that stalls RUN.
module addr_seq9
    import addr_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    input  logic [SW-1:0] stride,
`ifdef ADDR_SEQ_PAUSE_EN
    input  logic          pause,
`endif
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [SW-1:0] r_stride;
    logic [SW-1:0] w_stride_nxt;
    logic          r_en;
    logic          w_en_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_load;
    logic          w_dec;
    logic [LW-1:0] w_load_val;
    logic          w_last;
    logic          w_pause;

`ifdef ADDR_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    len_counter u_len_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_val),
        .o_last     (w_last)
    );

    // Next-state and next-output decode; an address is consumed only in a cycle where en was high.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_stride_nxt = r_stride;
        w_en_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_val   = sat_len(len);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_stride_nxt = stride;
                    if (len != {LW{1'b0}}) begin
                        w_state_nxt = ST_RUN;
                        w_addr_nxt  = base;
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_busy_nxt = 1'b1;
                if (r_en) begin
                    w_dec = 1'b1;
                    if (w_last) begin
                        // Last address was just shown: addr stays on it through DONE.
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + {{(AW-SW){1'b0}}, r_stride};
                        w_en_nxt   = ~w_pause;
                    end
                end else begin
                    // Stalled cycle: address and count held, resume when pause drops.
                    w_en_nxt = ~w_pause;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= {AW{1'b0}};
            r_stride <= {SW{1'b0}};
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_stride <= w_stride_nxt;
            r_en     <= w_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign addr = r_addr;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_addr_seq9.sv
// Self-checking bench for addr_seq9: directed plan cases plus random bursts
// compared against an address-list model built from base/len/stride arithmetic.
module tb_addr_seq9;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] base;
    logic [9:0] len;
    logic [3:0] stride;
    logic [8:0] addr;
    logic       en;
    logic       busy;
    logic       done;
`ifdef ADDR_SEQ_PAUSE_EN
    logic       pause;
`endif

    int total;
    int bad;

    addr_seq9 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .len    (len),
        .stride (stride),
`ifdef ADDR_SEQ_PAUSE_EN
        .pause  (pause),
`endif
        .addr   (addr),
        .en     (en),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_pause(input logic p);
`ifdef ADDR_SEQ_PAUSE_EN
        pause = p;
`endif
    endtask

    // Launch one burst and follow it to completion, checking every cycle.
    task automatic run_burst(input int b, input int l, input int s,
                             input logic [63:0] pat, input int restart_k);
        int exp_q[$];
        int n;
        int idx;
        int budget;
        bit finished;
        logic exp_en;
        n = (l > 512) ? 512 : l;
        for (int i = 0; i < n; i++) exp_q.push_back((b + i * s) % 512);
        @(negedge clk);
        base = 9'(b); len = 10'(l); stride = 4'(s); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        finished = 1'b0;
        budget = n + 100;
        for (int k = 0; k < budget; k++) begin
            if (k > 0) @(negedge clk);
            if (done === 1'b1) begin
                check("count", idx, n);
                check("done_en", en, 1'b0);
                check("done_busy", busy, 1'b0);
                if (n > 0) check("done_addr", addr, exp_q[n-1]);
                finished = 1'b1;
                break;
            end
            if (idx >= n) begin
                check("overrun", idx, n);
                finished = 1'b1;
                break;
            end
            exp_en = (k == 0) ? 1'b1 : ~pat[(k-1) % 64];
            if (k > 64) exp_en = 1'b1;
            check("busy", busy, 1'b1);
            check("en", en, exp_en);
            check("addr", addr, exp_q[idx]);
            if (en === 1'b1) idx++;
            // Scramble inputs mid-burst: the latched values must be unaffected.
            base = 9'($urandom); len = 10'($urandom); stride = 4'($urandom);
            start = (k == restart_k) ? 1'b1 : 1'b0;
            set_pause((k < 64) ? pat[k] : 1'b0);
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        start = 1'b0;
        set_pause(1'b0);
        @(negedge clk);
        check("idle_en", en, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
    endtask

    initial begin
        logic [63:0] pat;
        int b;
        int l;
        int s;
        total = 0;
        bad = 0;
        rst_n = 1'b0; start = 1'b0; base = 9'd0; len = 10'd0; stride = 4'd0;
        set_pause(1'b0);
        repeat (2) @(negedge clk);
        check("rst_addr", addr, 9'd0);
        check("rst_en", en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(5,   4,   1,  64'd0, -1);
        run_burst(510, 4,   1,  64'd0, -1);
        run_burst(3,   3,   0,  64'd0, -1);
        run_burst(0,   3,   15, 64'd0, -1);
        run_burst(77,  0,   4,  64'd0, -1);
        run_burst(9,   700, 1,  64'd0, 100);
        run_burst(200, 512, 7,  64'd0, 3);

        // Reset during the third address of a burst.
        @(negedge clk);
        base = 9'd20; len = 10'd10; stride = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_a0", addr, 9'd20);
        @(negedge clk);
        check("mid_a1", addr, 9'd22);
        @(negedge clk);
        check("mid_a2", addr, 9'd24);
        check("mid_en2", en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_addr", addr, 9'd0);
        check("arst_en", en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 1'b0);
            check("post_rst_en", en, 1'b0);
        end
        run_burst(100, 5, 3, 64'd0, -1);

`ifdef ADDR_SEQ_PAUSE_EN
        run_burst(8, 3, 1, 64'b011, -1);
`endif

        for (int i = 0; i < 14; i++) begin
            b = $urandom_range(0, 511);
            l = (i % 5 == 0) ? 0 : $urandom_range(1, 40);
            s = $urandom_range(0, 15);
            pat = 64'd0;
`ifdef ADDR_SEQ_PAUSE_EN
            pat = {$urandom, $urandom} & {$urandom, $urandom};
`endif
            run_burst(b, l, s, pat, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
